// File: rtl/execute_hazard_ctrl.sv
// Execute-stage hazard controller: ALU operand forwarding, load-use and branch stall/flush,
// and a multi-cycle (MUL) sequencer. Define HAZARD_STATS_EN to add saturating stall/flush counters.
module execute_hazard_ctrl #(
  parameter int MUL_LATENCY = 3,
  parameter int STAT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            Rs1D,
  input  logic [4:0]            Rs2D,
  input  logic [4:0]            Rs1E,
  input  logic [4:0]            Rs2E,
  input  logic [4:0]            RdE,
  input  logic [4:0]            RdM,
  input  logic [4:0]            RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic [1:0]            ResultSrcE,
  input  logic                  PCSrcE,
  input  logic                  MulStartE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
`ifdef HAZARD_STATS_EN
  output logic [STAT_WIDTH-1:0] StallCount,
  output logic [STAT_WIDTH-1:0] FlushCount,
`endif
  output logic                  MulDoneE
);

  localparam int CNT_W    = $clog2(MUL_LATENCY) + 1;
  localparam int CNT_INIT = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             mul_stall;
  logic             lw_stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic wr_m, input logic [4:0] rd_w,
                                         input logic wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))      return 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (MulStartE && (MUL_LATENCY > 1)) begin
        cnt_nxt   = CNT_W'(CNT_INIT);
        state_nxt = (MUL_LATENCY == 2) ? DONE : BUSY;
      end
      BUSY: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gating with rst_n keeps E free while reset is held, even if MulStartE is still high.
  always_comb begin
    mul_stall = rst_n && ((state == BUSY) ||
                          ((state == IDLE) && MulStartE && (MUL_LATENCY > 1)));
    MulDoneE  = (state == DONE) ||
                ((MUL_LATENCY == 1) && (state == IDLE) && MulStartE);
  end

  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    // A held multi-cycle op owns E; branch and load-use handling wait until it retires.
    if (mul_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + STAT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF)          StallCount <= sat_inc(StallCount);
      if (FlushD || FlushE) FlushCount <= sat_inc(FlushCount);
    end
  end
`endif

endmodule

// File: tb/tb_execute_hazard_ctrl.sv
// Directed self-checking bench for execute_hazard_ctrl (MUL_LATENCY=3, STAT_WIDTH=2);
// the counter checks are built only when HAZARD_STATS_EN is defined.
module tb_execute_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, PCSrcE, MulStartE;
  logic [1:0] ResultSrcE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDoneE;
`ifdef HAZARD_STATS_EN
  logic [1:0] StallCount, FlushCount;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  execute_hazard_ctrl #(.MUL_LATENCY(3), .STAT_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulStartE(MulStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
`ifdef HAZARD_STATS_EN
    .StallCount(StallCount), .FlushCount(FlushCount),
`endif
    .MulDoneE(MulDoneE)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packs the six stall/flush outputs as {StallF,StallD,StallE,FlushD,FlushE,FlushM}.
  function automatic logic [15:0] ctl();
    return {10'd0, StallF, StallD, StallE, FlushD, FlushE, FlushM};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, PCSrcE} = '0;
    ResultSrcE = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    MulStartE = 1'b0;
    clear_inputs();
    settle();
    check("reset_fwdA", 16'(ForwardAE), 16'h0);
    check("reset_ctl", ctl(), 16'b000000);
    check("reset_done", 16'(MulDoneE), 16'h0);
    MulStartE = 1'b1;
    settle();
    check("reset_mulstart_ctl", ctl(), 16'b000000);
    MulStartE = 1'b0;
    tick();
    rst_n = 1'b1;

    // Forwarding priority
    RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5; RdW = 5'd5; RegWriteW = 1'b1;
    settle();
    check("fwdA_m_priority", 16'(ForwardAE), 16'h2);
    check("fwdB_none", 16'(ForwardBE), 16'h0);
    RdM = 5'd0;
    settle();
    check("fwdA_rdm0_w", 16'(ForwardAE), 16'h1);
    Rs2E = 5'd5;
    settle();
    check("fwdB_w", 16'(ForwardBE), 16'h1);
    RdM = 5'd5; RegWriteW = 1'b0;
    settle();
    check("fwdB_m", 16'(ForwardBE), 16'h2);
    RegWriteM = 1'b0; RegWriteW = 1'b1;
    settle();
    check("fwdA_w_only", 16'(ForwardAE), 16'h1);
    Rs1E = 5'd0; RdW = 5'd0;
    settle();
    check("fwdA_x0", 16'(ForwardAE), 16'h0);
    clear_inputs();

    // Load-use
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    settle();
    check("lw_rs2", ctl(), 16'b110010);
    RdE = 5'd0;
    settle();
    check("lw_rde0", ctl(), 16'b000000);
    RdE = 5'd7; Rs2D = 5'd0; Rs1D = 5'd7;
    settle();
    check("lw_rs1", ctl(), 16'b110010);
    ResultSrcE = 2'b00;
    settle();
    check("lw_not_load", ctl(), 16'b000000);
    ResultSrcE = 2'b01; PCSrcE = 1'b1;
    settle();
    check("branch_over_lw", ctl(), 16'b000110);
    clear_inputs();
    tick();

    // MUL latency 3
    MulStartE = 1'b1;
    settle();
    check("mul_t_ctl", ctl(), 16'b111001);
    check("mul_t_done", 16'(MulDoneE), 16'h0);
    tick();
    ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
    settle();
    check("mul_t1_ctl_lw_suppressed", ctl(), 16'b111001);
    check("mul_t1_done", 16'(MulDoneE), 16'h0);
    clear_inputs();
    tick();
    settle();
    check("mul_t2_ctl", ctl(), 16'b000000);
    check("mul_t2_done", 16'(MulDoneE), 16'h1);
    tick();
    MulStartE = 1'b0;
    settle();
    check("mul_t3_done", 16'(MulDoneE), 16'h0);
    check("mul_t3_ctl", ctl(), 16'b000000);
    tick();

    // Reset in the middle of BUSY
    MulStartE = 1'b1;
    settle();
    check("rmul_t_ctl", ctl(), 16'b111001);
    tick();
    rst_n = 1'b0;
    settle();
    check("rmul_reset_ctl", ctl(), 16'b000000);
    check("rmul_reset_done", 16'(MulDoneE), 16'h0);
    tick();
    rst_n = 1'b1;
    settle();
    check("rmul_restart_t", ctl(), 16'b111001);
    tick();
    settle();
    check("rmul_restart_t1", ctl(), 16'b111001);
    tick();
    settle();
    check("rmul_restart_t2_ctl", ctl(), 16'b000000);
    check("rmul_restart_t2_done", 16'(MulDoneE), 16'h1);
    tick();
    MulStartE = 1'b0;

`ifdef HAZARD_STATS_EN
    rst_n = 1'b0;
    settle();
    check("stats_reset_stall", 16'(StallCount), 16'h0);
    check("stats_reset_flush", 16'(FlushCount), 16'h0);
    tick();
    rst_n = 1'b1;
    ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
    tick();
    tick();
    check("stats_stall_2", 16'(StallCount), 16'h2);
    check("stats_flush_2", 16'(FlushCount), 16'h2);
    tick();
    tick();
    tick();
    clear_inputs();
    settle();
    check("stats_stall_sat", 16'(StallCount), 16'h3);
    check("stats_flush_sat", 16'(FlushCount), 16'h3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
